// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with multiply/divide result write-back,
// MTHI/MTLO moves and an optionally pipelined 64-bit MADD/MSUB accumulate.
module hilo_unit #(
  parameter logic [31:0] RESET_HI = 32'h0000_0000,
  parameter logic [31:0] RESET_LO = 32'h0000_0000,
  parameter bit          ACC_PIPE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Finish,
  input  logic        i_IsDiv,
  input  logic [1:0]  i_ExtendOp,
  input  logic [31:0] i_toHI,
  input  logic [31:0] i_toLO,
  input  logic        i_MTHI,
  input  logic        i_MTLO,
  input  logic [31:0] i_WData,
  input  logic        i_Flush,
  output logic [31:0] o_HI,
  output logic [31:0] o_LO,
  output logic        o_Busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic [63:0] prod_r, prod_nxt_s;
  logic        sub_r, sub_nxt_s;
  logic        busy_r;

  logic        acc_op_s;
  logic [63:0] cur_s, in_prod_s, acc_in_s, acc_lat_s;

  // Operand selection and both 64-bit accumulate results (carry/borrow dropped)
  always_comb begin
    cur_s     = {hi_r, lo_r};
    in_prod_s = {i_toHI, i_toLO};
    acc_op_s  = !i_IsDiv && ((i_ExtendOp == 2'b01) || (i_ExtendOp == 2'b10));
    acc_in_s  = (i_ExtendOp == 2'b10) ? (cur_s - in_prod_s) : (cur_s + in_prod_s);
    acc_lat_s = sub_r ? (cur_s - prod_r) : (cur_s + prod_r);
  end

  // Next-state and HI/LO write arbitration: flush > result write > MT move
  always_comb begin
    state_nxt_s = state_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    prod_nxt_s  = prod_r;
    sub_nxt_s   = sub_r;
    case (state_r)
      IDLE: begin
        if (i_Flush) begin
          state_nxt_s = IDLE;
        end else if (i_Finish && acc_op_s && ACC_PIPE) begin
          prod_nxt_s  = in_prod_s;
          sub_nxt_s   = (i_ExtendOp == 2'b10);
          state_nxt_s = ACC;
        end else if (i_Finish && acc_op_s) begin
          {hi_nxt_s, lo_nxt_s} = acc_in_s;
        end else if (i_Finish) begin
          hi_nxt_s = i_toHI;
          lo_nxt_s = i_toLO;
        end else begin
          if (i_MTHI) begin
            hi_nxt_s = i_WData;
          end else begin
            hi_nxt_s = hi_r;
          end
          if (i_MTLO) begin
            lo_nxt_s = i_WData;
          end else begin
            lo_nxt_s = lo_r;
          end
        end
      end
      ACC: begin
        // New results are held off by o_Busy, so i_Finish is ignored here
        if (i_Flush) begin
          state_nxt_s = IDLE;
        end else begin
          {hi_nxt_s, lo_nxt_s} = acc_lat_s;
          state_nxt_s          = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, HI/LO, latched product and busy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      hi_r    <= RESET_HI;
      lo_r    <= RESET_LO;
      prod_r  <= 64'h0000_0000_0000_0000;
      sub_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      prod_r  <= prod_nxt_s;
      sub_r   <= sub_nxt_s;
      busy_r  <= (state_nxt_s == ACC);
    end
  end

  assign o_HI   = hi_r;
  assign o_LO   = lo_r;
  assign o_Busy = busy_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench: a pipelined instance (ACC_PIPE=1, zero reset)
// and a single-cycle instance (ACC_PIPE=0, non-zero reset) sharing stimulus.
module tb_hilo_unit;

  logic        clk, rst, rst_b;
  logic        i_Finish, i_IsDiv, i_MTHI, i_MTLO, i_Flush;
  logic [1:0]  i_ExtendOp;
  logic [31:0] i_toHI, i_toLO, i_WData;
  logic [31:0] hi_a, lo_a, hi_b, lo_b;
  logic        busy_a, busy_b;
  int          total_r, bad_r;

  hilo_unit u_dut_a (
    .clk(clk), .rst(rst), .i_Finish(i_Finish), .i_IsDiv(i_IsDiv),
    .i_ExtendOp(i_ExtendOp), .i_toHI(i_toHI), .i_toLO(i_toLO),
    .i_MTHI(i_MTHI), .i_MTLO(i_MTLO), .i_WData(i_WData), .i_Flush(i_Flush),
    .o_HI(hi_a), .o_LO(lo_a), .o_Busy(busy_a)
  );

  hilo_unit #(
    .RESET_HI(32'hA5A5_0001), .RESET_LO(32'h5A5A_0002), .ACC_PIPE(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .i_Finish(i_Finish), .i_IsDiv(i_IsDiv),
    .i_ExtendOp(i_ExtendOp), .i_toHI(i_toHI), .i_toLO(i_toLO),
    .i_MTHI(i_MTHI), .i_MTLO(i_MTLO), .i_WData(i_WData), .i_Flush(i_Flush),
    .o_HI(hi_b), .o_LO(lo_b), .o_Busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_r++;
    if (got !== exp) begin
      bad_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_Finish = 1'b0; i_IsDiv = 1'b0; i_ExtendOp = 2'b00;
    i_toHI = 32'h0; i_toLO = 32'h0;
    i_MTHI = 1'b0; i_MTLO = 1'b0; i_WData = 32'h0; i_Flush = 1'b0;
  endtask

  task automatic fin(input logic [1:0] op, input logic [31:0] h, input logic [31:0] l);
    idle();
    i_Finish = 1'b1; i_ExtendOp = op; i_toHI = h; i_toLO = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_r = 0; bad_r = 0;
    idle();
    rst = 1'b1; rst_b = 1'b1;
    #12;
    chk("reset_a", {hi_a, lo_a}, 64'h0);
    chk("reset_busy_a", {63'h0, busy_a}, 64'h0);
    chk("reset_b", {hi_b, lo_b}, 64'hA5A5_0001_5A5A_0002);

    // first edge after reset release accepts the MULT write
    rst = 1'b0;
    fin(2'b00, 32'h0000_0001, 32'hFFFF_FFFE);
    step();
    chk("mult", {hi_a, lo_a}, 64'h0000_0001_FFFF_FFFE);
    chk("mult_busy", {63'h0, busy_a}, 64'h0);

    idle(); i_MTLO = 1'b1; i_WData = 32'hFFFF_FFFF;
    step();
    chk("mtlo", {hi_a, lo_a}, 64'h0000_0001_FFFF_FFFF);
    idle(); i_MTHI = 1'b1; i_WData = 32'h0;
    step();
    chk("mthi", {hi_a, lo_a}, 64'h0000_0000_FFFF_FFFF);

    // MADD wrap; Finish and MTHI during ACC must be ignored
    fin(2'b01, 32'h0, 32'h1);
    step();
    chk("madd_busy", {63'h0, busy_a}, 64'h1);
    chk("madd_hold", {hi_a, lo_a}, 64'h0000_0000_FFFF_FFFF);
    fin(2'b00, 32'h7, 32'h7); i_MTHI = 1'b1; i_WData = 32'h3;
    step();
    chk("madd_res", {hi_a, lo_a}, 64'h0000_0001_0000_0000);
    chk("madd_busy_end", {63'h0, busy_a}, 64'h0);

    // MSUB underflow
    idle(); i_MTHI = 1'b1; i_MTLO = 1'b1; i_WData = 32'h0;
    step();
    fin(2'b10, 32'h0, 32'h1);
    step();
    chk("msub_busy", {63'h0, busy_a}, 64'h1);
    idle();
    step();
    chk("msub_res", {hi_a, lo_a}, 64'hFFFF_FFFF_FFFF_FFFF);

    // collision: result wins, MTHI dropped
    fin(2'b00, 32'h5, 32'h6); i_MTHI = 1'b1; i_WData = 32'h9;
    step();
    chk("collide", {hi_a, lo_a}, 64'h0000_0005_0000_0006);

    fin(2'b11, 32'h11, 32'h22);
    step();
    chk("op11_write", {hi_a, lo_a}, 64'h0000_0011_0000_0022);
    fin(2'b01, 32'h33, 32'h44); i_IsDiv = 1'b1;
    step();
    chk("div_write", {hi_a, lo_a}, 64'h0000_0033_0000_0044);
    chk("div_busy", {63'h0, busy_a}, 64'h0);

    // flush in IDLE suppresses both result and MT writes
    fin(2'b00, 32'h77, 32'h88); i_Flush = 1'b1; i_MTLO = 1'b1; i_WData = 32'h1;
    step();
    chk("flush_idle", {hi_a, lo_a}, 64'h0000_0033_0000_0044);

    // flush in ACC discards pending accumulate
    fin(2'b01, 32'h0, 32'h100);
    step();
    chk("fl_acc_busy", {63'h0, busy_a}, 64'h1);
    idle(); i_Flush = 1'b1;
    step();
    chk("fl_acc_busy_end", {63'h0, busy_a}, 64'h0);
    chk("fl_acc_val", {hi_a, lo_a}, 64'h0000_0033_0000_0044);
    idle();
    step();
    chk("fl_acc_after", {hi_a, lo_a}, 64'h0000_0033_0000_0044);

    // MADD with carry across the word boundary
    fin(2'b01, 32'h1, 32'hFFFF_FFC0);
    step();
    idle();
    step();
    chk("madd_carry", {hi_a, lo_a}, 64'h0000_0035_0000_0004);

    // async reset while in ACC
    fin(2'b01, 32'h0, 32'h5);
    step();
    chk("rst_acc_busy", {63'h0, busy_a}, 64'h1);
    idle();
    #3 rst = 1'b1;
    #1;
    chk("rst_async_val", {hi_a, lo_a}, 64'h0);
    chk("rst_async_busy", {63'h0, busy_a}, 64'h0);
    #1 rst = 1'b0;
    step();
    chk("rst_no_write", {hi_a, lo_a}, 64'h0);
    chk("rst_busy_after", {63'h0, busy_a}, 64'h0);

    // single-cycle accumulate instance
    rst_b = 1'b0;
    fin(2'b01, 32'h0, 32'h0000_FFFE);
    step();
    chk("p0_madd", {hi_b, lo_b}, 64'hA5A5_0001_5A5B_0000);
    chk("p0_busy", {63'h0, busy_b}, 64'h0);
    fin(2'b10, 32'hA5A5_0001, 32'h5A5B_0001);
    step();
    chk("p0_msub", {hi_b, lo_b}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p0_busy2", {63'h0, busy_b}, 64'h0);
    fin(2'b01, 32'h0, 32'h1); i_MTLO = 1'b1; i_WData = 32'h1234;
    step();
    chk("p0_collide", {hi_b, lo_b}, 64'h0);

    idle();
    $display("test done: total=%0d bad=%0d", total_r, bad_r);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The module SHALL have parameter RESET_HI, default 32'h0000_0000, giving the HI value loaded on reset.
REQ-002 The module SHALL have parameter RESET_LO, default 32'h0000_0000, giving the LO value loaded on reset.
REQ-003 The module SHALL have parameter ACC_PIPE, default 1: 1 selects a two-cycle MADD/MSUB accumulate, 0 selects a one-cycle accumulate.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 i_Finish  in  1  multiply/divide result valid this cycle.
REQ-008 i_IsDiv  in  1  qualifies i_Finish as a divide result; i_ExtendOp is ignored when set.
REQ-009 i_ExtendOp  in  2  00 = write, 01 = accumulate add, 10 = accumulate subtract, 11 = treated as 00.
REQ-010 i_toHI / i_toLO  in  32 each  result high/low words.
REQ-011 i_MTHI / i_MTLO  in  1 each  move-to-HI/LO write strobes.
REQ-012 i_WData  in  32  data for MTHI/MTLO.
REQ-013 i_Flush  in  1  exception flush from pipeline control.
REQ-014 o_HI / o_LO  out  32 each  architectural HI/LO registers.
REQ-015 o_Busy  out  1  accumulate in flight; the consumer stalls MFHI/MFLO and new mul/div issue while it is high.

Function
REQ-016 State machine states: IDLE, ACC (product latched, accumulate pending, ACC_PIPE=1 only).
REQ-017 In IDLE, i_Finish with (i_IsDiv or i_ExtendOp in {00,11}) SHALL load HI<=i_toHI and LO<=i_toLO at the next edge, with no change of state.
REQ-018 In IDLE with ACC_PIPE=1, i_Finish with !i_IsDiv and i_ExtendOp in {01,10} SHALL latch the 64-bit product {i_toHI,i_toLO} and the op, and go to ACC.
REQ-019 In ACC, {HI,LO} SHALL be updated to {HI,LO} + product (op 01) or {HI,LO} - product (op 10), mod 2^64, at the next edge; state returns to IDLE.
REQ-020 With ACC_PIPE=0, the accumulate SHALL complete at the edge following i_Finish; the ACC state is not used and o_Busy stays 0.
REQ-021 o_Busy SHALL be 1 exactly while state is ACC (one cycle per accumulate).
REQ-022 i_MTHI SHALL write HI<=i_WData and i_MTLO SHALL write LO<=i_WData at the next edge when not overridden by a result write.
REQ-023 When a result write (REQ-017, REQ-019) and MTHI/MTLO occur in the same cycle, the result write SHALL win for both words and the MT write SHALL be dropped.
REQ-024 i_Finish asserted while in ACC SHALL be ignored; the upstream stage is held off by o_Busy.
REQ-025 i_Flush SHALL suppress every write in its cycle, and a flush in ACC SHALL discard the pending accumulate and return to IDLE with HI/LO unchanged.
REQ-026 o_HI/o_LO SHALL be direct register outputs with no combinational path from any input.
REQ-027 Arithmetic SHALL be a full 64-bit two's-complement add/subtract; carry out and borrow SHALL be discarded.

Reset
REQ-028 On rst=1, asynchronously: HI=RESET_HI, LO=RESET_LO, state=IDLE, o_Busy=0, and the latched product and op SHALL be cleared.
REQ-029 Reset asserted in ACC SHALL abandon the accumulate with no write.
REQ-030 The first write after reset deassertion SHALL be accepted at the first rising edge with rst=0.

Verification
REQ-031 MULT write: i_Finish=1, ExtendOp=00, toHI=32'h1, toLO=32'hFFFF_FFFE -> next cycle HI=1, LO=FFFF_FFFE, o_Busy=0.
REQ-032 MADD wrap: HI/LO=0000_0000/FFFF_FFFF, ACC_PIPE=1, i_Finish with op 01 and product 0/1 -> o_Busy=1 for one cycle, then HI=1, LO=0.
REQ-033 MSUB underflow: HI/LO=0/0, op 10 with product 0/1 -> HI=FFFF_FFFF, LO=FFFF_FFFF.
REQ-034 Collision: i_Finish (op 00, 5/6) plus i_MTHI with WData=9 in the same cycle -> HI=5, LO=6.
REQ-035 Flush in ACC: MADD issued, i_Flush=1 during the ACC cycle -> HI/LO unchanged, o_Busy=0 on the following cycle.
REQ-036 Async reset mid-ACC: rst pulsed between edges -> HI/LO = RESET values immediately, o_Busy=0, with no later write.
